// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage constants and types.
// Holds ALU op classes, R-type function codes and the ALU-control enum.
package mips_pkg;

    localparam logic [1:0] ALU_OP_ADD  = 2'b00;
    localparam logic [1:0] ALU_OP_SUB  = 2'b01;
    localparam logic [1:0] ALU_OP_FUNC = 2'b10;
    localparam logic [1:0] ALU_OP_OR   = 2'b11;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU
    } alu_ctl_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, MEM/WB forwarding inputs and EX/MEM outputs of ex_stage.
// slave: the execute stage; master: whoever drives ID/EX and reads EX/MEM.
interface ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              reg_dst_idex;
    logic              reg_write_idex;
    logic              alu_src_idex;
    logic              mem_read_idex;
    logic              mem_write_idex;
    logic              branch_idex;
    logic              mem_to_reg_idex;
    logic [1:0]        alu_op_idex;
    logic [5:0]        func_idex;
    logic [DATA_W-1:0] signextend_idex;
    logic [DATA_W-1:0] pc4_idex;
    logic [DATA_W-1:0] rs_data_idex;
    logic [DATA_W-1:0] rt_data_idex;
    logic [REG_W-1:0]  rs_idex;
    logic [REG_W-1:0]  rt_idex;
    logic [REG_W-1:0]  rd_idex;

    logic              mem_wb_reg_write;
    logic [REG_W-1:0]  mem_wb_rd;
    logic [DATA_W-1:0] mem_wb_data;

    logic [DATA_W-1:0] alu_result_exmem;
    logic [DATA_W-1:0] store_data_exmem;
    logic [REG_W-1:0]  write_reg_exmem;
    logic              reg_write_exmem;
    logic              mem_read_exmem;
    logic              mem_write_exmem;
    logic              mem_to_reg_exmem;
    logic              branch_taken_exmem;
    logic [DATA_W-1:0] branch_target_exmem;
    logic              illegal_func_exmem;

    modport slave (
        input  reg_dst_idex, reg_write_idex, alu_src_idex,
        input  mem_read_idex, mem_write_idex, branch_idex,
        input  mem_to_reg_idex, alu_op_idex, func_idex,
        input  signextend_idex, pc4_idex,
        input  rs_data_idex, rt_data_idex,
        input  rs_idex, rt_idex, rd_idex,
        input  mem_wb_reg_write, mem_wb_rd, mem_wb_data,
        output alu_result_exmem, store_data_exmem,
        output write_reg_exmem, reg_write_exmem,
        output mem_read_exmem, mem_write_exmem,
        output mem_to_reg_exmem, branch_taken_exmem,
        output branch_target_exmem, illegal_func_exmem
    );

    modport master (
        output reg_dst_idex, reg_write_idex, alu_src_idex,
        output mem_read_idex, mem_write_idex, branch_idex,
        output mem_to_reg_idex, alu_op_idex, func_idex,
        output signextend_idex, pc4_idex,
        output rs_data_idex, rt_data_idex,
        output rs_idex, rt_idex, rd_idex,
        output mem_wb_reg_write, mem_wb_rd, mem_wb_data,
        input  alu_result_exmem, store_data_exmem,
        input  write_reg_exmem, reg_write_exmem,
        input  mem_read_exmem, mem_write_exmem,
        input  mem_to_reg_exmem, branch_taken_exmem,
        input  branch_target_exmem, illegal_func_exmem
    );
endinterface

// File: rtl/ex_stage_alu.sv
// Combinational ALU for the execute stage.
// Ports: a, b operands; ctl operation; result and zero flag.
module alu
    import mips_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  alu_ctl_t     ctl,
    output logic [W-1:0] result,
    output logic         zero
);
    logic slt;
    logic sltu;

    assign slt  = $signed(a) < $signed(b);
    assign sltu = a < b;

    always_comb begin
        result = '0;
        unique case (ctl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(W-1){1'b0}}, slt};
            ALU_SLTU: result = {{(W-1){1'b0}}, sltu};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU control, ALU, branch, EX/MEM register.
// Ports: clk, rst (async high), stall (hold), flush (bubble), bus (slave).
module ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       flush,
    ex_stage_if.slave  bus
);
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] target;
    logic [REG_W-1:0]  wr_reg;
    logic              alu_zero;
    logic              zero;
    logic              illegal;
    alu_ctl_t          ctl;

    // EX/MEM beats MEM/WB; r0 is never a forwarding source.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [REG_W-1:0]  idx,
        input logic [DATA_W-1:0] own
    );
        if (bus.reg_write_exmem &&
            bus.write_reg_exmem != '0 &&
            bus.write_reg_exmem == idx)
            return bus.alu_result_exmem;
        else if (bus.mem_wb_reg_write &&
                 bus.mem_wb_rd != '0 &&
                 bus.mem_wb_rd == idx)
            return bus.mem_wb_data;
        else
            return own;
    endfunction

    assign fwd_a = fwd(bus.rs_idex, bus.rs_data_idex);
    assign fwd_b = fwd(bus.rt_idex, bus.rt_data_idex);
    assign op_b  = bus.alu_src_idex ? bus.signextend_idex : fwd_b;

    always_comb begin
        ctl     = ALU_ADD;
        illegal = 1'b0;
        unique case (bus.alu_op_idex)
            ALU_OP_ADD: ctl = ALU_ADD;
            ALU_OP_SUB: ctl = ALU_SUB;
            ALU_OP_OR:  ctl = ALU_OR;
            default: begin
                unique case (bus.func_idex)
                    FUNCT_ADD:  ctl = ALU_ADD;
                    FUNCT_SUB:  ctl = ALU_SUB;
                    FUNCT_AND:  ctl = ALU_AND;
                    FUNCT_OR:   ctl = ALU_OR;
                    FUNCT_NOR:  ctl = ALU_NOR;
                    FUNCT_SLT:  ctl = ALU_SLT;
                    FUNCT_SLTU: ctl = ALU_SLTU;
                    default:    illegal = 1'b1;
                endcase
            end
        endcase
    end

    alu #(.W(DATA_W)) u_alu (
        .a      (fwd_a),
        .b      (op_b),
        .ctl    (ctl),
        .result (alu_res),
        .zero   (alu_zero)
    );

    // An unsupported func forces a zero result, hence zero=1.
    assign result = illegal ? '0 : alu_res;
    assign zero   = illegal | alu_zero;
    assign target = bus.pc4_idex + (bus.signextend_idex << 2);
    assign wr_reg = bus.reg_dst_idex ? bus.rd_idex : bus.rt_idex;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            bus.alu_result_exmem    <= '0;
            bus.store_data_exmem    <= '0;
            bus.write_reg_exmem     <= '0;
            bus.reg_write_exmem     <= 1'b0;
            bus.mem_read_exmem      <= 1'b0;
            bus.mem_write_exmem     <= 1'b0;
            bus.mem_to_reg_exmem    <= 1'b0;
            bus.branch_taken_exmem  <= 1'b0;
            bus.branch_target_exmem <= '0;
            bus.illegal_func_exmem  <= 1'b0;
        end else if (!stall) begin
            bus.alu_result_exmem    <= result;
            bus.store_data_exmem    <= fwd_b;
            bus.write_reg_exmem     <= wr_reg;
            bus.reg_write_exmem     <= bus.reg_write_idex;
            bus.mem_read_exmem      <= bus.mem_read_idex;
            bus.mem_write_exmem     <= bus.mem_write_idex;
            bus.mem_to_reg_exmem    <= bus.mem_to_reg_idex;
            bus.branch_taken_exmem  <= bus.branch_idex & zero;
            bus.branch_target_exmem <= target;
            bus.illegal_func_exmem  <= illegal;
        end
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. It consumes the ID/EX pipeline register outputs and resolves operands through EX/MEM and MEM/WB forwarding.
- It performs ALU-control decode, the ALU operation, branch evaluation and destination-register select.
- All results are captured in the EX/MEM pipeline register, which feeds the memory stage.
- The EX/MEM register supports stall (hold) and flush (bubble insertion).

Parameters:
- DATA_W, 32, datapath width.
- REG_W, 5, register-index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall  in  1  hold all EX/MEM registers
- flush  in  1  load a bubble into EX/MEM
- reg_dst_idex, reg_write_idex, alu_src_idex, mem_read_idex, mem_write_idex, branch_idex, mem_to_reg_idex  in  1 each  control from ID/EX
- alu_op_idex  in  2  ALU op class
- func_idex  in  6  R-type function field
- signextend_idex  in  DATA_W  sign-extended immediate
- pc4_idex  in  DATA_W  PC+4 of the instruction
- rs_data_idex, rt_data_idex  in  DATA_W  register-file operands
- rs_idex, rt_idex, rd_idex  in  REG_W  register indices
- mem_wb_reg_write  in  1  write-back stage write enable
- mem_wb_rd  in  REG_W  write-back destination
- mem_wb_data  in  DATA_W  write-back value
- alu_result_exmem  out  DATA_W  registered ALU result
- store_data_exmem  out  DATA_W  registered forwarded rt value
- write_reg_exmem  out  REG_W  registered destination index
- reg_write_exmem, mem_read_exmem, mem_write_exmem, mem_to_reg_exmem  out  1 each  registered control
- branch_taken_exmem  out  1  registered branch decision
- branch_target_exmem  out  DATA_W  registered branch target
- illegal_func_exmem  out  1  registered flag for an unsupported func code

Behaviour:
- Reset: rst is asynchronous, active-high; clock clk. While rst is high, every output is 0.
- Latency: one cycle. ID/EX inputs sampled at posedge N appear on the EX/MEM outputs after posedge N.
- Forwarding for operand A (rs) and B-source (rt) is combinational.
  - Source 1, EX/MEM: selected if reg_write_exmem=1, write_reg_exmem!=0 and write_reg_exmem equals the index. The forwarded value is alu_result_exmem.
  - Source 2, MEM/WB: otherwise selected if mem_wb_reg_write=1, mem_wb_rd!=0 and mem_wb_rd equals the index. The forwarded value is mem_wb_data.
  - Source 3: otherwise the ID/EX data.
  - EX/MEM has priority over MEM/WB.
  - Load-use hazards are not detected here. The upstream hazard unit stalls for them.
- Operand B: signextend_idex if alu_src_idex=1, else the forwarded rt.
- store_data always carries the forwarded rt, never the immediate.
- ALU control:
  - alu_op 00: ADD.
  - alu_op 01: SUB.
  - alu_op 11: OR (ori).
  - alu_op 10: decode func.
    - 100000 ADD
    - 100010 SUB
    - 100100 AND
    - 100101 OR
    - 100111 NOR
    - 101010 SLT (signed)
    - 101011 SLTU
  - Any other func with alu_op 10: result 0 and illegal_func=1.
- Arithmetic wraps modulo 2^DATA_W and there is no overflow trap. SLT/SLTU produce 0 or 1, zero-extended.
- zero = (ALU result == 0).
- branch_taken = branch_idex & zero.
- branch_target = pc4_idex + (signextend_idex << 2), truncated to DATA_W.
- write_reg = rd_idex if reg_dst_idex=1, else rt_idex.
- Flush (at posedge): reg_write, mem_read, mem_write, mem_to_reg, branch_taken and illegal_func are cleared. Data fields are don't-care; they are cleared to 0.
- Stall (at posedge): all EX/MEM registers hold their value.
- Priority: rst > flush > stall > normal load.
- Flush during stall: flush wins and the bubble is inserted.
- Reset asserted mid-stream clears everything immediately.

Decomposition:
- Shared package mips_pkg holds:
  - ALU_OP_* constants (2-bit).
  - FUNCT_* constants.
  - The internal ALU-control enum alu_ctl_t: ADD, SUB, AND, OR, NOR, SLT, SLTU.
- One sub-module, alu, is natural. It takes a, b and alu_ctl_t and is purely combinational, producing result and zero.
- Forwarding muxes, ALU-control decode and the EX/MEM register stay in ex_stage.

Test Plan:
- R-type ADD, no hazards: rs_data=5, rt_data=7, alu_op=10, func=100000, reg_dst=1, rd=3 -> after one posedge alu_result=12, write_reg=3, reg_write=1.
- EX/MEM forwarding: first instr writes r2=0x10. The next instr uses rs=2 with stale rs_data=0, computing SUB with rt_data=4 -> alu_result=0x0C.
- Double-hazard priority: EX/MEM writes r4=9 and MEM/WB writes r4=1 in the same cycle, next instr ADD r4+r0 -> result 9. Then with rd=0 on both, the ID/EX data is used.
- Branch: beq, alu_op=01, operands 8 and 8, pc4=0x100, imm=0x3 -> branch_taken=1, target=0x10C. With operands 8 and 9 -> branch_taken=0.
- Stall/flush: a stall held for 2 cycles keeps the outputs constant. Flush and stall asserted together -> reg_write, mem_write and branch_taken all 0 after the edge.
- SLT signed vs SLTU: a=0xFFFFFFFF, b=1 -> SLT gives 1, SLTU gives 0. func=000111 -> illegal_func=1, result 0. rst asserted mid-cycle clears all outputs before the next edge.
